// File: rtl/jesd204_tx_pkg.sv
// Shared constants and state encoding for the JESD204B transmit lane sequencer.
package jesd204_tx_pkg;

  localparam logic [7:0] K_CHAR = 8'hBC;  // K28.5
  localparam logic [7:0] R_CHAR = 8'h1C;  // K28.0
  localparam logic [7:0] A_CHAR = 8'h7C;  // K28.3
  localparam logic [7:0] Q_CHAR = 8'h9C;  // K28.4

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/jesd204_tx_sync_monitor.sv
// SYNC~ watchdog: long low runs request a resync, short low pulses are counted as errors.
module jesd204_tx_sync_monitor #(
  parameter int SYNC_ERR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sync,
  output logic       resync,
  output logic [7:0] err_count
);

  localparam logic [7:0] LOW_LAST = 8'(SYNC_ERR_CYCLES - 1);

  logic [7:0] low_cnt;

  // Fires in the cycle that completes the run, so the FSM leaves on this edge.
  assign resync = enable && !sync && (low_cnt == LOW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      low_cnt   <= '0;
      err_count <= '0;
    end else if (!enable || resync) begin
      low_cnt <= '0;
    end else if (!sync) begin
      low_cnt <= low_cnt + 8'd1;
    end else begin
      if (low_cnt != '0 && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      low_cnt <= '0;
    end
  end

endmodule

// File: rtl/jesd204_tx_lane_seq.sv
// Per-lane JESD204B TX link-layer sequencer: CGS /K/ stream, 4-multiframe ILAS, then user data.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_CGS  | sending /K/ until SYNC~ released on an LMFC edge
//   ST_ILAS | sending ILAS multiframes, counters free-running
//   ST_DATA | forwarding tx_data, SYNC~ monitor may force back to CGS
module jesd204_tx_lane_seq
  import jesd204_tx_pkg::*;
#(
  parameter int BEATS_PER_MF     = 8,
  parameter int ILAS_MULTIFRAMES = 4,
  parameter int SYNC_ERR_CYCLES  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync,
  input  logic         lmfc_edge,
  input  logic [111:0] ilas_config,
  input  logic [31:0]  tx_data,
  output logic         tx_ready,
  output logic [31:0]  phy_data,
  output logic [3:0]   phy_charisk,
  output logic [1:0]   status_state,
  output logic [7:0]   err_count
);

  localparam int BW = $clog2(BEATS_PER_MF);
  localparam int MW = (ILAS_MULTIFRAMES > 2) ? $clog2(ILAS_MULTIFRAMES) : 1;
  localparam logic [BW-1:0] LAST_B = BW'(BEATS_PER_MF - 1);
  localparam logic [MW-1:0] LAST_M = MW'(ILAS_MULTIFRAMES - 1);
  localparam logic [MW-1:0] M_ONE  = MW'(1);

  tx_state_e     state;
  logic [BW-1:0] beat_cnt, next_b, sel_b;
  logic [MW-1:0] mf_cnt, next_m, sel_m;
  logic          resync;
  logic [7:0]    cfg [14];
  logic [7:0]    oct [4];
  logic [3:0]    ilas_k;
  logic [31:0]   ilas_data;

  jesd204_tx_sync_monitor #(
    .SYNC_ERR_CYCLES(SYNC_ERR_CYCLES)
  ) u_sync_monitor (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != ST_CGS),
    .sync     (sync),
    .resync   (resync),
    .err_count(err_count)
  );

  assign status_state = state;
  assign next_b = (beat_cnt == LAST_B) ? '0 : beat_cnt + 1'b1;
  assign next_m = (beat_cnt == LAST_B) ? mf_cnt + 1'b1 : mf_cnt;
  // The ILAS word is always built for the beat about to be registered.
  assign sel_b = (state == ST_CGS) ? '0 : next_b;
  assign sel_m = (state == ST_CGS) ? '0 : next_m;

  always_comb begin
    for (int n = 0; n < 14; n++) cfg[n] = ilas_config[8*n +: 8];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      oct[i]    = 8'(4 * int'(sel_b) + i);
      ilas_k[i] = 1'b0;
    end
    if (sel_m == M_ONE) begin
      if (sel_b == '0) begin
        oct[1]    = Q_CHAR;
        ilas_k[1] = 1'b1;
        oct[2]    = cfg[0];
        oct[3]    = cfg[1];
      end else if (sel_b <= BW'(3)) begin
        for (int i = 0; i < 4; i++) oct[i] = cfg[4'(4 * int'(sel_b) - 2 + i)];
      end
    end
    if (sel_b == '0) begin
      oct[0]    = R_CHAR;
      ilas_k[0] = 1'b1;
    end
    // /A/ closes every multiframe, even if it lands on a config beat.
    if (sel_b == LAST_B) begin
      oct[3]    = A_CHAR;
      ilas_k[3] = 1'b1;
    end
  end

  assign ilas_data = {oct[3], oct[2], oct[1], oct[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CGS;
      beat_cnt    <= '0;
      mf_cnt      <= '0;
      phy_data    <= {4{K_CHAR}};
      phy_charisk <= 4'hF;
      tx_ready    <= 1'b0;
    end else begin
      case (state)
        ST_CGS: begin
          beat_cnt <= '0;
          mf_cnt   <= '0;
          tx_ready <= 1'b0;
          if (sync && lmfc_edge) begin
            state       <= ST_ILAS;
            phy_data    <= ilas_data;
            phy_charisk <= ilas_k;
          end else begin
            phy_data    <= {4{K_CHAR}};
            phy_charisk <= 4'hF;
          end
        end
        ST_ILAS: begin
          if (resync) begin
            state       <= ST_CGS;
            beat_cnt    <= '0;
            mf_cnt      <= '0;
            phy_data    <= {4{K_CHAR}};
            phy_charisk <= 4'hF;
            tx_ready    <= 1'b0;
          end else if (beat_cnt == LAST_B && mf_cnt == LAST_M) begin
            state       <= ST_DATA;
            beat_cnt    <= '0;
            mf_cnt      <= '0;
            phy_data    <= tx_data;
            phy_charisk <= 4'h0;
            tx_ready    <= 1'b1;
          end else begin
            beat_cnt    <= next_b;
            mf_cnt      <= next_m;
            phy_data    <= ilas_data;
            phy_charisk <= ilas_k;
            // Ready goes up with the last ILAS beat so data follows with no gap.
            tx_ready    <= (next_b == LAST_B) && (next_m == LAST_M);
          end
        end
        ST_DATA: begin
          if (resync) begin
            state       <= ST_CGS;
            phy_data    <= {4{K_CHAR}};
            phy_charisk <= 4'hF;
            tx_ready    <= 1'b0;
          end else begin
            phy_data    <= tx_data;
            phy_charisk <= 4'h0;
            tx_ready    <= 1'b1;
          end
        end
        default: begin
          state       <= ST_CGS;
          phy_data    <= {4{K_CHAR}};
          phy_charisk <= 4'hF;
          tx_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jesd204_tx_lane_seq.sv
// Directed bench for jesd204_tx_lane_seq with default parameters (8 beats x 4 multiframes, 4-cycle resync).
module tb_jesd204_tx_lane_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync;
  logic         lmfc_edge;
  logic [111:0] ilas_config;
  logic [31:0]  tx_data;
  logic         tx_ready;
  logic [31:0]  phy_data;
  logic [3:0]   phy_charisk;
  logic [1:0]   status_state;
  logic [7:0]   err_count;

  int checks = 0;
  int errors = 0;

  jesd204_tx_lane_seq dut (
    .clk         (clk),
    .reset       (reset),
    .sync        (sync),
    .lmfc_edge   (lmfc_edge),
    .ilas_config (ilas_config),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .phy_data    (phy_data),
    .phy_charisk (phy_charisk),
    .status_state(status_state),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cgs(input string tag);
    chk({tag, "_data"},  phy_data, 32'hBCBCBCBC);
    chk({tag, "_k"},     {28'd0, phy_charisk}, 32'hF);
    chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd0);
    chk({tag, "_state"}, {30'd0, status_state}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    sync      = 1'b0;
    lmfc_edge = 1'b0;
    tx_data   = 32'h0;
    for (int n = 0; n < 14; n++) ilas_config[8*n +: 8] = 8'(n);
    step(); step(); step();
    chk_cgs("reset");
    chk("reset_err", {24'd0, err_count}, 32'd0);
    reset = 1'b0;

    // 1: held in CGS while SYNC~ low
    for (int c = 0; c < 20; c++) begin
      step();
      chk_cgs("cgs_hold");
    end

    // 2: SYNC~ release, LMFC edge three cycles later, full ILAS
    sync = 1'b1;
    step(); step(); step();
    chk("pre_lmfc_state", {30'd0, status_state}, 32'd0);
    lmfc_edge = 1'b1;
    step();
    lmfc_edge = 1'b0;
    chk("mf0b0_data",  phy_data, 32'h0302011C);
    chk("mf0b0_k",     {28'd0, phy_charisk}, 32'h1);
    chk("mf0b0_state", {30'd0, status_state}, 32'd1);
    chk("mf0b0_ready", {31'd0, tx_ready}, 32'd0);
    for (int j = 1; j < 32; j++) begin
      step();
      if (j == 7) begin
        chk("mf0b7_data", phy_data, 32'h7C1E1D1C);
        chk("mf0b7_k",    {28'd0, phy_charisk}, 32'h8);
      end
      if (j == 8) begin
        chk("mf1b0_data", phy_data, 32'h01009C1C);
        chk("mf1b0_k",    {28'd0, phy_charisk}, 32'h3);
      end
      if (j == 9)  chk("mf1b1_data", phy_data, 32'h05040302);
      if (j == 11) begin
        chk("mf1b3_data", phy_data, 32'h0D0C0B0A);
        chk("mf1b3_k",    {28'd0, phy_charisk}, 32'h0);
      end
      if (j == 16) begin
        chk("mf2b0_data", phy_data, 32'h0302011C);
        chk("mf2b0_k",    {28'd0, phy_charisk}, 32'h1);
      end
      if (j == 30) chk("ready_before_last", {31'd0, tx_ready}, 32'd0);
    end
    chk("mf3b7_data",  phy_data, 32'h7C1E1D1C);
    chk("mf3b7_k",     {28'd0, phy_charisk}, 32'h8);
    chk("mf3b7_ready", {31'd0, tx_ready}, 32'd1);
    chk("mf3b7_state", {30'd0, status_state}, 32'd1);

    // 3: first data word directly after the last ILAS beat
    tx_data = 32'h11223344;
    step();
    chk("data0",       phy_data, 32'h11223344);
    chk("data0_k",     {28'd0, phy_charisk}, 32'h0);
    chk("data0_state", {30'd0, status_state}, 32'd2);
    chk("data0_ready", {31'd0, tx_ready}, 32'd1);
    tx_data = 32'hAABBCCDD;
    step();
    chk("data1", phy_data, 32'hAABBCCDD);

    // 4: short SYNC~ pulse counts an error, long one forces CGS
    sync = 1'b0;
    step(); step();
    sync = 1'b1;
    step();
    chk("short_err",   {24'd0, err_count}, 32'd1);
    chk("short_state", {30'd0, status_state}, 32'd2);
    sync = 1'b0;
    step(); step(); step();
    chk("low3_state", {30'd0, status_state}, 32'd2);
    step();
    chk_cgs("resync");
    chk("resync_err", {24'd0, err_count}, 32'd1);

    // 5a: SYNC~ high without LMFC edge
    sync = 1'b1;
    for (int c = 0; c < 100; c++) step();
    chk_cgs("no_lmfc");

    // 5b: SYNC~ drops one cycle before the LMFC edge
    sync = 1'b0;
    step();
    lmfc_edge = 1'b1;
    step();
    lmfc_edge = 1'b0;
    chk_cgs("sync_drop");
    step();
    chk_cgs("sync_drop2");

    // 5c: 300 short pulses saturate err_count
    sync      = 1'b1;
    lmfc_edge = 1'b1;
    step();
    lmfc_edge = 1'b0;
    for (int j = 1; j < 33; j++) step();
    chk("sat_entry_state", {30'd0, status_state}, 32'd2);
    for (int p = 0; p < 300; p++) begin
      sync = 1'b0;
      step();
      sync = 1'b1;
      step();
    end
    chk("sat_err",   {24'd0, err_count}, 32'd255);
    chk("sat_state", {30'd0, status_state}, 32'd2);
    sync = 1'b0;
    step(); step(); step(); step();
    chk_cgs("sat_resync");
    chk("sat_resync_err", {24'd0, err_count}, 32'd255);

    // 6: reset at MF2 beat 5, then restart ILAS
    sync      = 1'b1;
    lmfc_edge = 1'b1;
    step();
    lmfc_edge = 1'b0;
    for (int j = 1; j < 22; j++) step();
    chk("mf2b5_data",  phy_data, 32'h17161514);
    chk("mf2b5_state", {30'd0, status_state}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_cgs("mid_reset");
    chk("mid_reset_err", {24'd0, err_count}, 32'd0);
    lmfc_edge = 1'b1;
    step();
    lmfc_edge = 1'b0;
    chk("restart_b0",       phy_data, 32'h0302011C);
    chk("restart_b0_state", {30'd0, status_state}, 32'd1);
    for (int j = 1; j < 8; j++) step();
    chk("restart_b7", phy_data, 32'h7C1E1D1C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_lane_seq.md
# jesd204_tx_lane_seq

Per-lane JESD204B transmit link-layer sequencer. It answers the receiver's SYNC~ request: it emits /K/ code-group-sync characters while SYNC~ is asserted, then the 4-multiframe ILAS aligned to the LMFC, then user data. It sits between the TX transport layer and the 8b/10b/PHY interface, one instance per lane, and is the transmit-side peer of the RX sync/ILAS logic exercised in the loopback system bench.

## Interface
- `BEATS_PER_MF`, 8, beats (4 octets each) per multiframe; legal range 4..64.
- `ILAS_MULTIFRAMES`, 4, number of ILAS multiframes; legal range 2..8.
- `SYNC_ERR_CYCLES`, 4, consecutive SYNC~-low cycles that count as a resync request; legal range 2..255.
- Ports:
  - `clk` in 1: link clock (one beat per cycle).
  - `reset` in 1: synchronous, active-high.
  - `sync` in 1: SYNC~ from receiver. Active-low. Already synchronised to `clk`.
  - `lmfc_edge` in 1: one-cycle pulse on the first beat of each local multiframe.
  - `ilas_config` in 112: 14 ILAS configuration octets. Octet n is at bits [8n+7:8n].
  - `tx_data` in 32: user data, 4 octets.
  - `tx_ready` out 1: `tx_data` is consumed in this cycle.
  - `phy_data` out 32: octet 0 is at [7:0] and is sent first.
  - `phy_charisk` out 4: per-octet K-character flag.
  - `status_state` out 2: 0 = CGS, 1 = ILAS, 2 = DATA.
  - `err_count` out 8: saturating count of short SYNC~ error pulses.

## Operation
- Reset values:
  - `phy_data` = 32'hBCBCBCBC, `phy_charisk` = 4'hF.
  - `tx_ready` = 0, `status_state` = 0, `err_count` = 0.
  - Internal state is CGS; beat and multiframe counters are 0.
- K-character codes: /K/ = K28.5 = 8'hBC; /R/ = K28.0 = 8'h1C; /A/ = K28.3 = 8'h7C; /Q/ = K28.4 = 8'h9C.
- **CGS**
  - Every beat outputs 32'hBCBCBCBC with charisk 4'hF.
  - Exit to ILAS only in a cycle where `sync` = 1 and `lmfc_edge` = 1.
  - `sync` high without `lmfc_edge` keeps the block in CGS.
- **ILAS**
  - Beat counter b runs 0..`BEATS_PER_MF`-1; multiframe counter m runs 0..`ILAS_MULTIFRAMES`-1.
  - Both counters free-run once started; `lmfc_edge` is ignored.
  - Default octet i of beat b is the ramp value (4b+i) mod 256, charisk 0.
  - Overrides:
    - b = 0, octet 0: /R/.
    - b = last beat, octet 3: /A/.
    - m = 1, b = 0: octet 1 is /Q/, octets 2..3 are cfg0..cfg1.
    - m = 1, b = 1..3: cfg2..cfg13 in order.
  - Every control character sets its charisk bit.
  - After the last beat of the last multiframe, go to DATA.
- **DATA**
  - `tx_ready` = 1.
  - `phy_data` = `tx_data` registered, charisk 0.
  - Character replacement and scrambling are outside this block.
- **SYNC~ monitor** (active in ILAS and DATA)
  - Counts consecutive `sync` = 0 cycles.
  - Count reaches `SYNC_ERR_CYCLES`: enter CGS at that clock edge, clear `tx_ready`.
  - `sync` returns high after 1..`SYNC_ERR_CYCLES`-1 low cycles: increment `err_count`, saturating at 255. State is unchanged.
  - In CGS the monitor counter is held at 0 and no errors are counted.
- A simultaneous resync request and ILAS-complete resolves to CGS.
- `reset` overrides everything, including mid-ILAS or mid-DATA.

## Timing
- All outputs are registered.
- Latency from CGS exit: when `lmfc_edge` = 1 and `sync` = 1 in cycle t, ILAS beat 0 of multiframe 0 appears on `phy_data` in cycle t+1. The LMFC offset upstream absorbs this fixed 1-cycle delay.
- ILAS lasts exactly `BEATS_PER_MF` × `ILAS_MULTIFRAMES` cycles.
- ILAS to DATA hand-off:
  - The last ILAS beat is output in cycle n.
  - `tx_ready` = 1 from cycle n.
  - `tx_data` sampled at the end of cycle n appears in cycle n+1.
  - There is no gap beat.
- `tx_ready` has no backpressure: in DATA the upstream must present valid data every cycle.
- Resync latency: `/K/` appears in the cycle after the cycle in which the low count reaches `SYNC_ERR_CYCLES`.
- `status_state` changes in the same cycle as the first beat of the new phase on `phy_data`.

## Structure
- Shared package `jesd204_tx_pkg` holds:
  - the K-character constants (8'hBC, 8'h1C, 8'h7C, 8'h9C);
  - the state enum (CGS = 0, ILAS = 1, DATA = 2).
- Sub-module `jesd204_tx_sync_monitor` implements the low-cycle counter, the resync request pulse and the saturating `err_count`.
- The top module holds the FSM, the beat/multiframe counters and the output mux/register.

## Test plan
Defaults: `BEATS_PER_MF` = 8, `ILAS_MULTIFRAMES` = 4, `SYNC_ERR_CYCLES` = 4.

1. Reset, then hold `sync` = 0 for 20 cycles → `phy_data` = 32'hBCBCBCBC, charisk 4'hF, `tx_ready` = 0, `status_state` = 0 throughout.
2. Raise `sync`, pulse `lmfc_edge` 3 cycles later, `ilas_config` = octets 0x00..0x0D → the ILAS words below, and `status_state` = 2 after 32 ILAS beats.

   | ILAS beat | `phy_data` | charisk |
   |---|---|---|
   | MF0 beat 0 | 32'h0302011C | 4'b0001 |
   | MF0 beat 7 | 32'h7C1E1D1C | 4'b1000 |
   | MF1 beat 0 | 32'h01009C1C | 4'b0011 |
   | MF1 beat 3 | 32'h0D0C0B0A | 4'b0000 |

3. Drive `tx_data` = 32'h11223344 in the first `tx_ready` cycle → `phy_data` = 32'h11223344 with charisk 0 on the next cycle, directly after the last ILAS beat (32'h7C1E1D1C).
4. In DATA:
   - pulse `sync` low for 2 cycles → `err_count` = 1, state stays DATA;
   - then hold it low for 4 cycles → `phy_data` = 32'hBCBCBCBC on the following cycle, `status_state` = 0, `err_count` stays 1.
5. Boundary checks, each leaving the block in CGS:
   - `sync` high with no `lmfc_edge` for 100 cycles;
   - `sync` dropping 1 cycle before `lmfc_edge`;
   - 300 short error pulses → `err_count` saturates at 255.
6. Assert `reset` at MF2 beat 5 → next cycle `phy_data` = 32'hBCBCBCBC, `err_count` = 0; a fresh `sync`/`lmfc_edge` restarts ILAS at MF0 beat 0.
